// File: rtl/aes_data_path.sv
// Iterative AES-128 encryption datapath: one cipher round per clock with the
// round keys expanded on the fly from the supplied cipher key. A block is
// captured on the edge where i_dp_en is seen while idle; the ciphertext and a
// one-cycle o_flag pulse appear ten edges later.
// Optional build macro AES_DP_BUSY_PORT_EN adds an o_busy output that mirrors
// the internal busy register.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] tblIdx;

  assign tblIdx = 11'd2047 - {in_i, 3'b000};
  assign out_o  = SBOX_TABLE[tblIdx -: 8];

endmodule

module aes_data_path #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int MAX_CNT  = 10,
  parameter int CNT_SIZE = 4,
  parameter int NUM_RND  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_dp_en,
  input  logic [RND_SIZE-1:0] i_rnd_text,
  input  logic [RND_SIZE-1:0] i_rnd_key,
  output logic [RND_SIZE-1:0] o_cypher_text,
  output logic                o_flag
`ifdef AES_DP_BUSY_PORT_EN
  ,
  output logic                o_busy
`endif
);

  // The terminal count never runs past the number of AES rounds.
  localparam logic [CNT_SIZE-1:0] CNT_LAST =
    CNT_SIZE'((MAX_CNT < NUM_RND) ? MAX_CNT : NUM_RND);

  logic [RND_SIZE-1:0] state_q, state_d;
  logic [RND_SIZE-1:0] rkey_q, rkey_d;
  logic [RND_SIZE-1:0] ct_q, ct_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                flag_q, flag_d;

  logic [RND_SIZE-1:0] subState;
  logic [RND_SIZE-1:0] shiftState;
  logic [RND_SIZE-1:0] mixState;
  logic [RND_SIZE-1:0] rkeyNext;

  logic [WRD_SIZE-1:0] keyRot;
  logic [WRD_SIZE-1:0] keySub;
  logic [WRD_SIZE-1:0] keyTemp;
  logic [7:0]          rconByte;

  // GF(2^8) multiply by 2, reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column, byte a0 in the top bits.
  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Round constant for the key produced in round cnt (1..10).
  function automatic logic [7:0] rconOf(input logic [CNT_SIZE-1:0] cnt);
    logic [7:0] rc;
    case (cnt)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // SubBytes over all sixteen state bytes; byte 0 sits in the top bits.
  for (genvar i = 0; i < NUM_BLK * 4; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_i  (state_q[RND_SIZE-1-8*i -: 8]),
      .out_o (subState[RND_SIZE-1-8*i -: 8])
    );
  end

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  for (genvar c = 0; c < NUM_BLK; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign shiftState[RND_SIZE-1-8*(4*c+r) -: 8] =
        subState[RND_SIZE-1-8*(4*((c+r)%NUM_BLK)+r) -: 8];
    end
  end

  // MixColumns column by column.
  for (genvar c = 0; c < NUM_BLK; c++) begin : g_mix_col
    assign mixState[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE] =
      mixColumn(shiftState[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE]);
  end

  // Key schedule: RotWord then SubWord on the last word of the current key.
  assign keyRot = {rkey_q[WRD_SIZE-9:0], rkey_q[WRD_SIZE-1:WRD_SIZE-8]};

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_i  (keyRot[WRD_SIZE-1-8*k -: 8]),
      .out_o (keySub[WRD_SIZE-1-8*k -: 8])
    );
  end

  assign rconByte = rconOf(cnt_q);
  assign keyTemp  = keySub ^ {rconByte, 24'h000000};

  assign rkeyNext[127:96] = rkey_q[127:96] ^ keyTemp;
  assign rkeyNext[95:64]  = rkey_q[95:64]  ^ rkeyNext[127:96];
  assign rkeyNext[63:32]  = rkey_q[63:32]  ^ rkeyNext[95:64];
  assign rkeyNext[31:0]   = rkey_q[31:0]   ^ rkeyNext[63:32];

  // Round sequencing: capture while idle, nine full rounds, then the final
  // round without MixColumns which publishes the result and pulses the flag.
  always_comb begin
    state_d = state_q;
    rkey_d  = rkey_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    flag_d  = 1'b0;
    if (!busy_q) begin
      if (i_dp_en) begin
        state_d = i_rnd_text ^ i_rnd_key;
        rkey_d  = i_rnd_key;
        cnt_d   = CNT_SIZE'(1);
        busy_d  = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      state_d = shiftState ^ rkeyNext;
      rkey_d  = rkeyNext;
      ct_d    = shiftState ^ rkeyNext;
      cnt_d   = '0;
      busy_d  = 1'b0;
      flag_d  = 1'b1;
    end else begin
      state_d = mixState ^ rkeyNext;
      rkey_d  = rkeyNext;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Datapath registers; reset abandons any block in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= '0;
      rkey_q  <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
    end
  end

  assign o_cypher_text = ct_q;
  assign o_flag        = flag_q;

`ifdef AES_DP_BUSY_PORT_EN
  assign o_busy = busy_q;
`endif

endmodule

// File: tb/tb_aes_data_path.sv
// Self-checking bench for aes_data_path: directed FIPS-197 style vectors, a
// scoreboard of expected ciphertexts with their due cycle, and a monitor that
// checks every flag pulse plus the held output between pulses.

module tb_aes_data_path;

  logic         clk;
  logic         rst_n;
  logic         i_dp_en;
  logic [127:0] i_rnd_text;
  logic [127:0] i_rnd_key;
  logic [127:0] o_cypher_text;
  logic         o_flag;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t sbQ[$];
  int   flagCycles[$];
  int   cycle;
  int   checks;
  int   failures;
  logic [127:0] heldCt;

  localparam logic [127:0] TXT0 = 128'h0;
  localparam logic [127:0] KEY0 = 128'h0;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TXTA = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEYA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTA  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] TXTB = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEYB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CTB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_data_path dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_dp_en       (i_dp_en),
    .i_rnd_text    (i_rnd_text),
    .i_rnd_key     (i_rnd_key),
    .o_cypher_text (o_cypher_text),
    .o_flag        (o_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start request; the expectation is queued only when wanted.
  task automatic applyStimulus(input logic [127:0] txt, input logic [127:0] key,
                               input logic [127:0] ct, input bit expectIt);
    @(negedge clk);
    i_rnd_text = txt;
    i_rnd_key  = key;
    i_dp_en    = 1'b1;
    @(posedge clk);
    #1;
    if (expectIt) sbQ.push_back('{ct, cycle + 10});
    i_dp_en = 1'b0;
  endtask

  // Wait for the scoreboard to drain, bounded by a cycle budget.
  task automatic waitIdle();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbQ.size());
      sbQ.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // Monitor: pop and compare on each flag, otherwise the output must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      heldCt = '0;
      checkOutput("reset_ct", o_cypher_text, 128'h0);
      checkOutput("reset_flag", {127'h0, o_flag}, 128'h0);
    end else if (o_flag) begin
      flagCycles.push_back(cycle);
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_flag: got flag at cycle %0d expected none", cycle);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("ciphertext", o_cypher_text, e.ct);
        checkOutput("latency", 128'(cycle), 128'(e.due));
        heldCt = e.ct;
      end
    end else begin
      checkOutput("hold", o_cypher_text, heldCt);
    end
  end

  initial begin
    int s;
    checks     = 0;
    failures   = 0;
    heldCt     = '0;
    i_dp_en    = 1'b0;
    i_rnd_text = '0;
    i_rnd_key  = '0;
    rst_n      = 1'b0;
    #2 rst_n   = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;

    // Idle after reset: nothing happens without a start request.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_ct", o_cypher_text, 128'h0);
    checkOutput("idle_flag", {127'h0, o_flag}, 128'h0);

    // All-zero text and key.
    applyStimulus(TXT0, KEY0, CT0, 1'b1);
    waitIdle();

    // FIPS-197 appendix B vector.
    applyStimulus(TXTA, KEYA, CTA, 1'b1);
    waitIdle();

    // Appendix C vector with inputs changed and a start pulse mid-run.
    applyStimulus(TXTB, KEYB, CTB, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    i_rnd_text = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    i_rnd_key  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    i_dp_en    = 1'b1;
    @(posedge clk);
    #1 i_dp_en = 1'b0;
    waitIdle();
    repeat (12) @(posedge clk);
    #1 checkOutput("held_after_ignore", o_cypher_text, CTB);

    // Held-high start with alternating vectors: back-to-back every 11 cycles.
    flagCycles.delete();
    @(negedge clk);
    i_rnd_text = TXTA;
    i_rnd_key  = KEYA;
    i_dp_en    = 1'b1;
    @(posedge clk);
    #1;
    s = cycle;
    sbQ.push_back('{CTA, s + 10});
    i_rnd_text = TXTB;
    i_rnd_key  = KEYB;
    sbQ.push_back('{CTB, s + 21});
    repeat (11) @(posedge clk);
    #1;
    i_rnd_text = TXTA;
    i_rnd_key  = KEYA;
    sbQ.push_back('{CTA, s + 32});
    repeat (11) @(posedge clk);
    #1 i_dp_en = 1'b0;
    waitIdle();
    checkOutput("flag_count", 128'(flagCycles.size()), 128'd3);
    if (flagCycles.size() == 3) begin
      checkOutput("spacing_1", 128'(flagCycles[1] - flagCycles[0]), 128'd11);
      checkOutput("spacing_2", 128'(flagCycles[2] - flagCycles[1]), 128'd11);
    end

    // Reset in the middle of a block: outputs clear at once, no flag follows.
    applyStimulus(TXTB, KEYB, CTB, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("abort_ct", o_cypher_text, 128'h0);
    checkOutput("abort_flag", {127'h0, o_flag}, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (15) @(posedge clk);

    // A fresh start after the abort completes normally.
    applyStimulus(TXTA, KEYA, CTA, 1'b1);
    waitIdle();
    checkOutput("final_ct", o_cypher_text, CTA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
